// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the Rx pin / shift-register block and the UART receive bit-timing
// controller. master = pin/flag side, slave = the controller.
interface uart_rx_ctrl_if;
    logic Rx;
    logic clr_frame_err;
    logic shift;
    logic load_buffer;
    logic busy;
    logic frame_err;

    modport master (
        output Rx,
        output clr_frame_err,
        input  shift,
        input  load_buffer,
        input  busy,
        input  frame_err
    );

    modport slave (
        input  Rx,
        input  clr_frame_err,
        output shift,
        output load_buffer,
        output busy,
        output frame_err
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive bit-timing controller: finds the start bit, issues mid-bit shift pulses and a
// load_buffer pulse after the stop bit. Define UART_RX_FRAME_ERR_EN to enable sticky frame_err.
module uart_rx_ctrl #(
    parameter int unsigned DIVISOR = 434,
    parameter int unsigned CNT_W   = 16
) (
    input  logic           CLOCK,
    input  logic           reset,
    uart_rx_ctrl_if.slave  rx_if
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIVISOR - 1);
    localparam logic [2:0]       LAST_BIT  = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [1:0]       r_sync;
    logic             r_shift;
    logic             r_load;
    logic             r_busy;
    logic             w_rx_s;

`ifdef UART_RX_FRAME_ERR_EN
    logic             r_frame_err;
`else
    logic             w_unused_clr;
`endif

    assign w_rx_s = r_sync[1];

    // Synchronizer, bit-timing counter and frame FSM with registered pulse outputs
    always_ff @(posedge CLOCK) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_sync      <= 2'b11;
            r_shift     <= 1'b0;
            r_load      <= 1'b0;
            r_busy      <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            r_frame_err <= 1'b0;
`endif
        end else begin
            r_sync  <= {r_sync[0], rx_if.Rx};
            r_shift <= 1'b0;
            r_load  <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            if (rx_if.clr_frame_err) begin
                r_frame_err <= 1'b0;
            end
`endif
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end

                START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt     <= '0;
                        r_shift   <= 1'b1;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == LAST_BIT) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_load  <= 1'b1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            // Low stop bit: wait for the line to recover before hunting again
`ifdef UART_RX_FRAME_ERR_EN
                            r_frame_err <= 1'b1;
`else
                            r_load      <= 1'b1;
`endif
                            r_state <= WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                WAIT_HIGH: begin
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.shift       = r_shift;
    assign rx_if.load_buffer = r_load;
    assign rx_if.busy        = r_busy;

`ifdef UART_RX_FRAME_ERR_EN
    assign rx_if.frame_err   = r_frame_err;
`else
    assign rx_if.frame_err   = 1'b0;
    assign w_unused_clr      = rx_if.clr_frame_err;
`endif

endmodule
